// File: rtl/fetch_stage_pkg.sv
// Shared CPU types and defaults for the fetch pipeline stage.
// Holds the fetch FSM encoding, opcode width and reset defaults.
package cpu_pkg;

  localparam int OPCODE_W = 3;
  localparam int ARQ_DEF = 16;
  localparam int RESET_PC_DEF = 0;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read bus between fetch_stage and the imem.
// master = fetch side, slave = memory side.
interface fetch_stage_if #(
  parameter int ARQ = 16
) ();

  logic [ARQ-1:0] imem_addr;
  logic           imem_rd_en;
  logic [ARQ-1:0] imem_rdata;

  modport master (
    output imem_addr,
    output imem_rd_en,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    input  imem_rd_en,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_stage_sat_counter.sv
// 16-bit saturating event counter with enable.
// Sticks at all-ones instead of wrapping.
module sat_counter
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, IF/ID register, jump flush FSM.
// Define FETCH_PERF_CNT_EN to build the fetch/bubble counters.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int ARQ = ARQ_DEF,
  parameter logic [ARQ-1:0] RESET_PC = ARQ'(RESET_PC_DEF)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pc_en,
  input  logic                stall,
  input  logic                jump_taken,
  input  logic [ARQ-1:0]      jump_target,
  fetch_stage_if.master       imem,
  output logic [ARQ-1:0]      ifid_instr,
  output logic [ARQ-1:0]      ifid_pc,
  output logic [OPCODE_W-1:0] ifid_opcode,
  output logic                ifid_valid,
  output logic [CNT_W-1:0]    fetch_cnt,
  output logic [CNT_W-1:0]    bubble_cnt
);

  fetch_state_t state_q, state_d;

  logic [ARQ-1:0] pc_q, pc_d;
  logic [ARQ-1:0] req_pc_q, req_pc_d;
  logic [ARQ-1:0] instr_q, instr_d;
  logic [ARQ-1:0] ifpc_q, ifpc_d;
  logic           valid_q, valid_d;

  logic advance;
  logic load_req;
  logic redirect;
  logic capture;

  assign advance  = pc_en & ~stall;
  assign load_req = (state_q != RUN);
  assign redirect = (state_q == RUN) & jump_taken;
  assign capture  = (state_q == RUN) & ~jump_taken & advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      FLUSH:   state_d = RUN;
      RUN:     if (jump_taken) state_d = FLUSH;
      default: state_d = BOOT;
    endcase
  end

  // Bubbles always carry a zero instruction; ifid_pc just holds.
  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    instr_d  = instr_q;
    ifpc_d   = ifpc_q;
    valid_d  = valid_q;
    unique case (1'b1)
      load_req: begin
        req_pc_d = pc_q;
        pc_d     = pc_q + ARQ'(1);
        instr_d  = '0;
        valid_d  = 1'b0;
      end
      redirect: begin
        pc_d    = jump_target;
        instr_d = '0;
        valid_d = 1'b0;
      end
      capture: begin
        instr_d  = imem.imem_rdata;
        ifpc_d   = req_pc_q;
        valid_d  = 1'b1;
        req_pc_d = pc_q;
        pc_d     = pc_q + ARQ'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      instr_q  <= '0;
      ifpc_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      instr_q  <= instr_d;
      ifpc_q   <= ifpc_d;
      valid_q  <= valid_d;
    end
  end

  // Read only when the data will be consumed so rdata holds in a stall.
  assign imem.imem_addr  = pc_q;
  assign imem.imem_rd_en = load_req | advance | jump_taken;

  assign ifid_instr  = instr_q;
  assign ifid_pc     = ifpc_q;
  assign ifid_valid  = valid_q;
  assign ifid_opcode = instr_q[ARQ-1 -: OPCODE_W];

`ifdef FETCH_PERF_CNT_EN
  logic bubble_inc;

  assign bubble_inc = load_req | redirect;

  sat_counter u_fetch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (capture),
    .cnt   (fetch_cnt)
  );

  sat_counter u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bubble_inc),
    .cnt   (bubble_cnt)
  );
`else
  assign fetch_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
